// File: rtl/wave_tbl_pkg.sv
// Shared state encoding, default widths and address-wrap helper for the wave table sequencer.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package wave_tbl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  localparam int WT_A  = 4;
  localparam int WT_D  = 16;
  localparam int WT_DW = 8;

  // Next table entry: back to first after last, otherwise +1 modulo 2**aw
  function automatic logic [31:0] next_addr(input logic [31:0] cur,
                                            input logic [31:0] first,
                                            input logic [31:0] last,
                                            input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    if (cur == last) return first;
    return (cur + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/wave_tbl_dwell_ctr.sv
// Per-entry repeat counter: loads the dwell value, counts down one per transfer.
// Latency: load/dec take effect on the next clock; zero flag is combinational from the count.
// Backpressure: dec is only asserted on an accepted transfer, so stalls simply hold the count.
module wave_tbl_dwell_ctr #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [DW-1:0] load_val,
  output logic          zero
);

  logic [DW-1:0] cnt;

  // Load wins over decrement; never wraps below zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/wave_tbl_seq.sv
// Steps the wave table from first_addr to last_addr, emitting each entry dwell+1 times on a valid/ready stream.
// Latency: start in cycle N gives out_valid in N+2; one bubble between entries unless WAVE_TBL_SEQ_PREFETCH_EN.
// Backpressure: out_valid holds with stable data until out_ready; WAVE_TBL_SEQ_PREFETCH_EN removes the inter-entry bubble.
module wave_tbl_seq
  import wave_tbl_pkg::*;
#(
  parameter int A  = WT_A,
  parameter int D  = WT_D,
  parameter int DW = WT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [A-1:0]  first_addr,
  input  logic [A-1:0]  last_addr,
  input  logic [DW-1:0] dwell,
  output logic [A-1:0]  tbl_addr,
  input  logic [D-1:0]  tbl_sigA,
  input  logic [D-1:0]  tbl_sigB,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D-1:0]  out_sigA,
  output logic [D-1:0]  out_sigB,
  output logic [A-1:0]  out_idx,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [A-1:0]  addr;
  logic [A-1:0]  first_q;
  logic [A-1:0]  last_q;
  logic [A-1:0]  nxt;
  logic [DW-1:0] dwell_q;
  logic          loop_q;
  logic          stop_pend;

  logic hs;
  logic abort;
  logic finish;
  logic advance;
  logic cnt_zero;
  logic cnt_load;
  logic cnt_dec;

  assign nxt  = A'(next_addr(32'(addr), 32'(first_q), 32'(last_q), A));
  assign busy = (state != ST_IDLE);

`ifdef WAVE_TBL_SEQ_PREFETCH_EN
  // While emitting, look up the following entry so it can be loaded without a bubble
  assign tbl_addr = (state == ST_EMIT) ? nxt : addr;
`else
  assign tbl_addr = addr;
`endif

  // Handshake decode: end of sequence, abort, or step to the next entry
  always_comb begin
    hs       = (state == ST_EMIT) && out_valid && out_ready;
    abort    = stop || stop_pend;
    finish   = hs && (abort || (cnt_zero && (addr == last_q) && !loop_q));
    advance  = hs && cnt_zero && !finish;
    cnt_dec  = hs && !cnt_zero;
    cnt_load = (state == ST_FETCH) && !abort;
`ifdef WAVE_TBL_SEQ_PREFETCH_EN
    cnt_load = cnt_load || advance;
`endif
  end

  wave_tbl_dwell_ctr #(.DW(DW)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (dwell_q),
    .zero     (cnt_zero)
  );

  // Sequencer FSM with config latches and registered sample outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      first_q   <= '0;
      last_q    <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
      stop_pend <= 1'b0;
      out_valid <= 1'b0;
      out_sigA  <= '0;
      out_sigB  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // stop is ignored here, including when it coincides with start
          if (start) begin
            first_q   <= first_addr;
            last_q    <= last_addr;
            dwell_q   <= dwell;
            loop_q    <= loop_en;
            addr      <= first_addr;
            stop_pend <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            state     <= ST_IDLE;
            stop_pend <= 1'b0;
            done      <= 1'b1;
          end else begin
            out_sigA  <= tbl_sigA;
            out_sigB  <= tbl_sigB;
            out_idx   <= addr;
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (finish) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            stop_pend <= 1'b0;
            done      <= 1'b1;
          end else begin
            // A stop without a handshake waits for the current sample to be taken
            if (stop) stop_pend <= 1'b1;
            if (advance) begin
              addr <= nxt;
`ifdef WAVE_TBL_SEQ_PREFETCH_EN
              out_sigA <= tbl_sigA;
              out_sigB <= tbl_sigB;
              out_idx  <= nxt;
`else
              out_valid <= 1'b0;
              state     <= ST_FETCH;
`endif
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
